// File: rtl/cve2_pkg.sv
// Shared types for the core sleep controller: FSM state encoding and counter widths.
package cve2_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_SLEEP = 3'd3,
    S_WAKE  = 3'd4
  } sleep_state_e;

  localparam int WakeCntWidth = 16;

endpackage

// File: rtl/cve2_clock_gate.sv
// Latch-based clock gate: the enable is captured while clk_i is low so clk_o never glitches.
module cve2_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic r_en_latch;

  always_latch begin
    if (!clk_i) begin
      r_en_latch <= en_i | scan_cg_en_i;
    end
  end

  assign clk_o = clk_i & r_en_latch;

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// Core sleep controller: watches busy/wake activity, gates the core clock after an idle
// window and keeps saturating statistics of gated cycles and sleep exits.
module cve2_sleep_ctrl
  import cve2_pkg::*;
#(
  parameter int NumWake   = 16,
  parameter int IdleDelay = 4,
  parameter int CntWidth  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    test_en_i,
  input  logic                    fetch_enable_i,
  input  logic                    core_busy_i,
  input  logic [NumWake-1:0]      wake_i,
  input  logic [NumWake-1:0]      wake_mask_i,
  input  logic                    force_on_i,
  input  logic                    cnt_clr_i,
  output logic                    clk_o,
  output logic                    clock_en_o,
  output logic                    fetch_enable_o,
  output logic                    core_sleep_o,
  output logic [CntWidth-1:0]     sleep_cycles_o,
  output logic [WakeCntWidth-1:0] wake_count_o
);

  localparam int IdleW = (IdleDelay > 1) ? $clog2(IdleDelay) : 1;
  localparam logic [IdleW-1:0] IdleInit = (IdleDelay > 0) ? IdleW'(IdleDelay - 1) : '0;

  sleep_state_e            r_state;
  sleep_state_e            w_state_next;
  logic                    r_fetch_en;
  logic                    r_busy;
  logic [IdleW-1:0]        r_idle_cnt;
  logic [IdleW-1:0]        w_idle_cnt_next;
  logic [CntWidth-1:0]     r_sleep_cycles;
  logic [WakeCntWidth-1:0] r_wake_count;
  logic                    w_wake_any;
  logic                    w_wake_req;
  logic                    w_clock_en;
  logic                    w_core_sleep;
  logic                    w_wake_event;

  assign w_wake_any = force_on_i | (|(wake_i & wake_mask_i));
  assign w_wake_req = w_wake_any | r_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_OFF;
      r_fetch_en <= 1'b0;
      r_busy     <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_en <= r_fetch_en | fetch_enable_i;
      r_busy     <= core_busy_i;
      r_idle_cnt <= w_idle_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_idle_cnt_next = r_idle_cnt;
    w_clock_en      = 1'b0;
    case (r_state)
      S_OFF: begin
        if (r_fetch_en) w_state_next = S_RUN;
      end
      S_RUN: begin
        w_clock_en = 1'b1;
        if (!w_wake_req) begin
          if (IdleDelay == 0) begin
            w_state_next = S_SLEEP;
          end else begin
            w_state_next    = S_DRAIN;
            w_idle_cnt_next = IdleInit;
          end
        end
      end
      S_DRAIN: begin
        w_clock_en = 1'b1;
        // Activity on the last drain cycle must still cancel the sleep.
        if (w_wake_req) begin
          w_state_next = S_RUN;
        end else if (r_idle_cnt == '0) begin
          w_state_next = S_SLEEP;
        end else begin
          w_idle_cnt_next = r_idle_cnt - IdleW'(1);
        end
      end
      S_SLEEP: begin
        // Open the gate combinationally so the wake cycle itself is clocked.
        w_clock_en = w_wake_req;
        if (w_wake_req) w_state_next = S_WAKE;
      end
      S_WAKE: begin
        w_clock_en   = 1'b1;
        w_state_next = S_RUN;
      end
      default: w_state_next = S_OFF;
    endcase
  end

  assign w_core_sleep = (r_state == S_SLEEP) & ~w_clock_en;
  assign w_wake_event = (r_state == S_SLEEP) & w_wake_req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sleep_cycles <= '0;
      r_wake_count   <= '0;
    end else if (cnt_clr_i) begin
      r_sleep_cycles <= '0;
      r_wake_count   <= '0;
    end else begin
      if (w_core_sleep && !(&r_sleep_cycles)) r_sleep_cycles <= r_sleep_cycles + CntWidth'(1);
      if (w_wake_event && !(&r_wake_count))   r_wake_count   <= r_wake_count + WakeCntWidth'(1);
    end
  end

  cve2_clock_gate u_clock_gate (
    .clk_i        (clk_i),
    .en_i         (w_clock_en),
    .scan_cg_en_i (test_en_i),
    .clk_o        (clk_o)
  );

  assign clock_en_o     = w_clock_en;
  assign fetch_enable_o = r_fetch_en;
  assign core_sleep_o   = w_core_sleep;
  assign sleep_cycles_o = r_sleep_cycles;
  assign wake_count_o   = r_wake_count;

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Directed bench for cve2_sleep_ctrl: a vector table for the main FSM walk, plus
// hand-written sequences for counter saturation/clear, scan enable and mid-DRAIN reset.
module tb_cve2_sleep_ctrl;

  localparam int NumWake = 16;
  localparam int CntW    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               test_en;
  logic               fetch_en;
  logic               busy;
  logic [NumWake-1:0] wake;
  logic [NumWake-1:0] mask;
  logic               force_on;
  logic               clr;
  logic               clk_g;
  logic               clock_en;
  logic               fetch_en_o;
  logic               core_sleep;
  logic [CntW-1:0]    sleep_cycles;
  logic [15:0]        wake_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cve2_sleep_ctrl #(
    .NumWake   (NumWake),
    .IdleDelay (4),
    .CntWidth  (CntW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .test_en_i      (test_en),
    .fetch_enable_i (fetch_en),
    .core_busy_i    (busy),
    .wake_i         (wake),
    .wake_mask_i    (mask),
    .force_on_i     (force_on),
    .cnt_clr_i      (clr),
    .clk_o          (clk_g),
    .clock_en_o     (clock_en),
    .fetch_enable_o (fetch_en_o),
    .core_sleep_o   (core_sleep),
    .sleep_cycles_o (sleep_cycles),
    .wake_count_o   (wake_count)
  );

  typedef struct {
    logic        fe;
    logic        busy;
    logic [15:0] wake;
    logic [15:0] mask;
    logic        force_on;
    logic        e_ce;
    logic        e_sl;
    logic        e_fe;
    logic [3:0]  e_sc;
    logic [15:0] e_wc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fe, input logic b, input logic [15:0] w, input logic [15:0] m,
                     input logic f, input logic ce, input logic sl, input logic efe,
                     input logic [3:0] sc, input logic [15:0] wc);
    vec_t v;
    v.fe = fe; v.busy = b; v.wake = w; v.mask = m; v.force_on = f;
    v.e_ce = ce; v.e_sl = sl; v.e_fe = efe; v.e_sc = sc; v.e_wc = wc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; test_en = 1'b0; fetch_en = 1'b0; busy = 1'b0;
    wake = '0; mask = '0; force_on = 1'b0; clr = 1'b0;

    //   fe b  wake   mask   f   ce sl fe sc wc
    add(0, 0, 16'h0, 16'h0, 0,  0, 0, 0, 0, 0);  // OFF, idle
    add(1, 0, 16'h0, 16'h0, 0,  0, 0, 0, 0, 0);  // fetch pulse
    add(0, 1, 16'h0, 16'h0, 0,  0, 0, 1, 0, 0);  // sticky fe visible
    add(0, 1, 16'h0, 16'h0, 0,  1, 0, 1, 0, 0);  // RUN
    add(0, 0, 16'h0, 16'h0, 0,  1, 0, 1, 0, 0);  // busy drops (cycle T)
    for (int i = 0; i < 5; i++) add(0, 0, 16'h0, 16'h0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 16'h0, 16'h0, 0,  0, 1, 1, 0, 0);  // SLEEP at T+6
    add(0, 0, 16'h8, 16'h0, 0,  0, 1, 1, 1, 0);  // masked wake ignored
    add(0, 0, 16'h8, 16'h8, 0,  1, 0, 1, 2, 0);  // enabled wake: same-cycle clock
    add(0, 0, 16'h0, 16'h8, 0,  1, 0, 1, 2, 1);  // WAKE
    for (int i = 0; i < 5; i++) add(0, 0, 16'h0, 16'h0, 0, 1, 0, 1, 2, 1);
    add(0, 0, 16'h0, 16'h0, 0,  0, 1, 1, 2, 1);  // SLEEP again
    add(0, 0, 16'h8, 16'h0, 1,  1, 0, 1, 3, 1);  // force_on ignores mask
    add(0, 0, 16'h0, 16'h0, 0,  1, 0, 1, 3, 2);  // WAKE
    add(0, 1, 16'h0, 16'h0, 0,  1, 0, 1, 3, 2);
    add(0, 0, 16'h0, 16'h0, 0,  1, 0, 1, 3, 2);
    for (int i = 0; i < 4; i++) add(0, 0, 16'h0, 16'h0, 0, 1, 0, 1, 3, 2);
    add(0, 0, 16'h8, 16'h8, 0,  1, 0, 1, 3, 2);  // wake at idle_cnt=0
    add(0, 0, 16'h0, 16'h0, 0,  1, 0, 1, 3, 2);  // must be RUN, not SLEEP
    for (int i = 0; i < 4; i++) add(0, 0, 16'h0, 16'h0, 0, 1, 0, 1, 3, 2);
    add(0, 1, 16'h0, 16'h0, 0,  0, 1, 1, 3, 2);  // busy not yet registered
    add(0, 1, 16'h0, 16'h0, 0,  1, 0, 1, 4, 2);  // busy_q wakes
    add(0, 0, 16'h0, 16'h0, 0,  1, 0, 1, 4, 3);  // WAKE

    // Reset state
    #2;
    check("rst_clock_en", 32'(clock_en), 32'd0);
    check("rst_core_sleep", 32'(core_sleep), 32'd0);
    check("rst_fetch_en", 32'(fetch_en_o), 32'd0);
    check("rst_sleep_cycles", 32'(sleep_cycles), 32'd0);
    check("rst_wake_count", 32'(wake_count), 32'd0);
    step();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      fetch_en = vecs[i].fe; busy = vecs[i].busy; wake = vecs[i].wake;
      mask = vecs[i].mask; force_on = vecs[i].force_on;
      #2;
      $display("vec %0d: fe=%0b busy=%0b wake=%h mask=%h force=%0b -> ce=%0b sleep=%0b fe_o=%0b sc=%0d wc=%0d",
               i, fetch_en, busy, wake, mask, force_on, clock_en, core_sleep, fetch_en_o,
               sleep_cycles, wake_count);
      check($sformatf("vec%0d_clock_en", i), 32'(clock_en), 32'(vecs[i].e_ce));
      check($sformatf("vec%0d_core_sleep", i), 32'(core_sleep), 32'(vecs[i].e_sl));
      check($sformatf("vec%0d_fetch_en", i), 32'(fetch_en_o), 32'(vecs[i].e_fe));
      check($sformatf("vec%0d_sleep_cycles", i), 32'(sleep_cycles), 32'(vecs[i].e_sc));
      check($sformatf("vec%0d_wake_count", i), 32'(wake_count), 32'(vecs[i].e_wc));
      step();
    end
    fetch_en = 1'b0; busy = 1'b0; wake = '0; mask = '0; force_on = 1'b0;

    // Saturation of the 4-bit sleep counter, gated clock, scan enable, clear
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
        step();
        reached = core_sleep;
      end
      check("sat_sleep_reached", 32'(reached), 32'd1);
    end
    for (int i = 0; i < 20; i++) step();
    $display("saturation: sc=%0d clk_o=%0b", sleep_cycles, clk_g);
    check("sat_sleep_cycles", 32'(sleep_cycles), 32'hF);
    check("sat_clk_o_gated", 32'(clk_g), 32'd0);
    test_en = 1'b1;
    step();
    $display("scan: clk_o=%0b", clk_g);
    check("scan_clk_o_running", 32'(clk_g), 32'd1);
    check("scan_still_asleep", 32'(core_sleep), 32'd1);
    test_en = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    $display("clear: sc=%0d wc=%0d", sleep_cycles, wake_count);
    check("clr_sleep_cycles", 32'(sleep_cycles), 32'd0);
    check("clr_wake_count", 32'(wake_count), 32'd0);
    step();
    check("post_clr_sleep_cycles", 32'(sleep_cycles), 32'd1);

    // Reset mid-DRAIN (idle_cnt=2), then re-enable
    force_on = 1'b1;
    step();
    force_on = 1'b0;
    check("s6_wake_count", 32'(wake_count), 32'd1);
    step();
    step();
    step();
    check("s6_drain_clock_en", 32'(clock_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    $display("mid-drain reset: ce=%0b sleep=%0b fe_o=%0b sc=%0d wc=%0d",
             clock_en, core_sleep, fetch_en_o, sleep_cycles, wake_count);
    check("s6_rst_clock_en", 32'(clock_en), 32'd0);
    check("s6_rst_core_sleep", 32'(core_sleep), 32'd0);
    check("s6_rst_fetch_en", 32'(fetch_en_o), 32'd0);
    check("s6_rst_sleep_cycles", 32'(sleep_cycles), 32'd0);
    check("s6_rst_wake_count", 32'(wake_count), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("s6_off_clock_en%0d", i), 32'(clock_en), 32'd0);
    end
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    check("s6_refetch_fe", 32'(fetch_en_o), 32'd1);
    step();
    $display("re-enable: ce=%0b fe_o=%0b", clock_en, fetch_en_o);
    check("s6_run_clock_en", 32'(clock_en), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
